// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map, bit positions, default depth.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        RegData   = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegRsvd   = 2'd3
    } reg_sel_e;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_IRQ_EN    = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;
    localparam int unsigned STAT_COUNT_W   = 5;

    localparam int unsigned CTRL_IRQ_EN    = 0;
    localparam int unsigned CTRL_CLR_OVR   = 1;
    localparam int unsigned CTRL_FLUSH     = 2;

    localparam int unsigned DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/byte_fifo.sv
// Parameterised 8-bit synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every observation of it.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped UART receive controller: strobe edge detect, byte FIFO, overrun, registers, irq.
// Define UART_RX_IRQ_EN to build the irq_en register and interrupt logic; otherwise irq_o is 0.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_status_i,
    input  logic [7:0]  rx_data_i,
    input  logic [1:0]  addr_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    reg_sel_e      reg_sel;
    logic          rx_prev_q;
    logic          ovr_q, ovr_d;
    logic          push, pop, flush, clr_ovr, ovr_set, ctrl_wr, data_rd;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          irq_en;
    logic          unused_wdata;

    assign reg_sel      = reg_sel_e'(addr_i);
    assign unused_wdata = ^wdata_i[31:3];

    assign push    = rx_status_i & ~rx_prev_q;
    assign data_rd = mem_rd_i & (reg_sel == RegData);
    assign pop     = data_rd & ~empty;
    assign ctrl_wr = mem_wr_i & (reg_sel == RegCtrl);
    assign flush   = ctrl_wr & wdata_i[CTRL_FLUSH];
    assign clr_ovr = ctrl_wr & wdata_i[CTRL_CLR_OVR];
    // A flush swallows the incoming byte, so it can never count as an overrun.
    assign ovr_set = push & full & ~pop & ~flush;

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_prev_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_status_i;
            ovr_q     <= ovr_d;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (rx_data_i),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef UART_RX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wdata_i[CTRL_IRQ_EN];
            irq_q <= irq_en_q & (~empty | ovr_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    logic unused_irq_bit;

    assign unused_irq_bit = wdata_i[CTRL_IRQ_EN];
    assign irq_en         = 1'b0;
    assign irq_o          = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_sel)
            RegData: begin
                rdata_o[7:0] = empty ? 8'h00 : head;
            end
            RegStatus: begin
                rdata_o[STAT_NOT_EMPTY] = ~empty;
                rdata_o[STAT_FULL]      = full;
                rdata_o[STAT_OVERRUN]   = ovr_q;
                rdata_o[STAT_IRQ_EN]    = irq_en;
                rdata_o[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
            end
            RegCtrl: begin
                rdata_o[CTRL_IRQ_EN] = irq_en;
            end
            default: begin
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios then random traffic against a
// queue-based reference model. Honours UART_RX_IRQ_EN the same way the design does.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;
`ifdef UART_RX_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_status = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [1:0]  addr = 2'd0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_irq_en = 1'b0;
    logic       m_irq = 1'b0;
    logic       m_prev = 1'b0;

    uart_rx_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_status_i (rx_status),
        .rx_data_i   (rx_data),
        .addr_i      (addr),
        .mem_rd_i    (mem_rd),
        .mem_wr_i    (mem_wr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (mq.size() != 0) r[7:0] = mq[0];
            2'd1: begin
                r[0]   = (mq.size() != 0);
                r[1]   = (mq.size() == DEPTH);
                r[2]   = m_ovr;
                r[3]   = m_irq_en;
                r[8:4] = 5'(mq.size());
            end
            2'd2: r[0] = m_irq_en;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic rx, input logic [7:0] d, input logic [1:0] a,
                              input logic rd, input logic wr, input logic [31:0] wd);
        logic push, ctrl_wr, irq_nx, ovr_set;
        push    = rx && !m_prev;
        ctrl_wr = wr && (a == 2'd2);
        irq_nx  = m_irq_en && ((mq.size() != 0) || m_ovr);
        ovr_set = 1'b0;
        if (ctrl_wr && wd[2]) begin
            mq.delete();
        end else begin
            if (rd && a == 2'd0 && mq.size() != 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else ovr_set = 1'b1;
            end
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (ctrl_wr && wd[1]) m_ovr = 1'b0;
`ifdef UART_RX_IRQ_EN
        if (ctrl_wr) m_irq_en = wd[0];
`endif
        m_irq  = irq_nx;
        m_prev = rx;
    endtask

    // One bus cycle: drive on the falling edge, check outputs, advance the model.
    task automatic cycle(input logic rx, input logic [7:0] d, input logic [1:0] a,
                         input logic rd, input logic wr, input logic [31:0] wd,
                         output logic [31:0] got);
        @(negedge clk);
        rx_status = rx;
        rx_data   = d;
        addr      = a;
        mem_rd    = rd;
        mem_wr    = wr;
        wdata     = wd;
        #1;
        got = rdata;
        check_val("rdata", rdata, model_rdata(a));
        check_val("irq", {31'b0, irq}, {31'b0, m_irq});
        model_step(rx, d, a, rd, wr, wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_status = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr      = 2'd1;
        reset     = 1'b1;
        #1;
        check_val("reset_status", rdata, 32'h0);
        check_val("reset_irq", {31'b0, irq}, 32'h0);
        mq.delete();
        m_ovr    = 1'b0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
        m_prev   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] got;
    logic        r_rx, r_rd, r_wr;
    logic [7:0]  r_d;
    logic [1:0]  r_a;
    logic [31:0] r_wd;

    initial begin
        do_reset();

        // Reset state
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("rst_status", got, 32'h0);
        cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("rst_data", got, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);

        // Two bytes in, two bytes out
        cycle(1'b1, 8'h55, 2'd0, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b1, 8'hA3, 2'd0, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("two_status", got, 32'h21);
        cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("two_rd0", got, 32'h55);
        cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("two_rd1", got, 32'hA3);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("two_empty", got, 32'h0);

        // Overrun: five strobes into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(i + 1), 2'd1, 1'b0, 1'b0, 32'h0, got);
            cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        end
        check_val("ovr_status", got, 32'h47);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
            check_val("ovr_rd", got, 32'(i + 1));
        end
        cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("ovr_rd_empty", got, 32'h0);
        cycle(1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 32'h2, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("ovr_clear", got, 32'h0);

        // Full FIFO, strobe coincident with a DATA read
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 2'd1, 1'b0, 1'b0, 32'h0, got);
            cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        end
        cycle(1'b1, 8'h99, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("full_pushpop_rd", got, 32'h10);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("full_pushpop_status", got, 32'h43);
        cycle(1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 32'h4, got);

        // Interrupt timing
        cycle(1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 32'h1, got);
        cycle(1'b1, 8'h7E, 2'd1, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("irq_lag", {31'b0, irq}, 32'h0);
        cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 32'h0, got);
        check_val("irq_set", {31'b0, irq}, {31'b0, IRQ_BUILD});
        check_val("irq_pop_rd", got, 32'h7E);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("irq_clear", {31'b0, irq}, 32'h0);
        cycle(1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 32'h0, got);

        // Held strobe pushes once; flush beats a coincident strobe
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 32'h0, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("held_once", got, 32'h11);
        cycle(1'b1, 8'h22, 2'd2, 1'b0, 1'b1, 32'h4, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        check_val("flush_wins", got, 32'h0);

        // Reset in the middle of activity
        cycle(1'b1, 8'h33, 2'd2, 1'b0, 1'b1, 32'h1, got);
        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        do_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r_rx = ($urandom_range(0, 2) == 0);
            r_d  = 8'($urandom);
            r_a  = 2'($urandom_range(0, 3));
            r_rd = 1'($urandom_range(0, 1));
            r_wr = ($urandom_range(0, 7) == 0);
            r_wd = $urandom;
            if ($urandom_range(0, 3) != 0) r_wd[2] = 1'b0;
            cycle(r_rx, r_d, r_a, r_rd, r_wr, r_wd, got);
            if (i % 1000 == 999) do_reset();
        end

        cycle(1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 32'h0, got);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
